// File: rtl/bus_copy_master_if.sv
// Shared single-master bus between bus_copy_master and its slave/arbiter.
// m_req/m_grant handshake, word address, write strobe and both data directions.
interface bus_copy_master_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 64
);
  logic          m_req;
  logic          m_grant;
  logic          m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_dout;
  logic [DW-1:0] m_din;

  modport master (
    output m_req,
    output m_wr,
    output m_addr,
    output m_dout,
    input  m_grant,
    input  m_din
  );

  modport slave (
    input  m_req,
    input  m_wr,
    input  m_addr,
    input  m_dout,
    output m_grant,
    output m_din
  );
endinterface

// File: rtl/bus_copy_master.sv
// bus_copy_master: copies len words from src_addr to dst_addr over the shared bus,
// reading bursts of up to BUF_DEPTH words into a local buffer and writing them back.
// Optional feature macro: COPY_CHECKSUM_EN -- when defined, chk_out XOR-accumulates
// every word written; otherwise chk_out is tied to zero.
module bus_copy_master #(
  parameter int unsigned BUF_DEPTH = 4,
  parameter int unsigned AW        = 16,
  parameter int unsigned DW        = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [AW-1:0]     src_addr,
  input  logic [AW-1:0]     dst_addr,
  input  logic [AW-1:0]     len,
  output logic              busy,
  output logic              done,
  output logic [DW-1:0]     chk_out,
  bus_copy_master_if.master bus
);

  localparam int unsigned IW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StRd,
    StRdDrain,
    StWr,
    StFin
  } state_e;

  state_e        state_q;
  logic [AW-1:0] src_q;
  logic [AW-1:0] dst_q;
  logic [AW-1:0] rem_q;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] last_q;     // index of the final word of the current burst
  logic [IW-1:0] cap_idx_q;  // buffer slot for the read issued last cycle
  logic          rd_pend_q;  // a read was issued last cycle; its data is on m_din now
  logic          busy_q;
  logic          done_q;
  logic          req_q;
  logic          wr_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] dout_q;
  logic [DW-1:0] buf_mem [BUF_DEPTH];

  logic          rd_issue;
  logic          wr_issue;
  logic          last_beat;
  logic [AW-1:0] burst_len;
  logic [AW-1:0] rem_next;
  logic [IW-1:0] wr_sel;
  logic [DW-1:0] wr_word;

  // Last buffer index for a burst covering min(BUF_DEPTH, remaining) words.
  function automatic logic [IW-1:0] burst_last(input logic [AW-1:0] remaining);
    if (remaining >= AW'(BUF_DEPTH)) begin
      return IW'(BUF_DEPTH - 1);
    end
    return IW'(remaining - AW'(1));
  endfunction

  assign rd_issue  = (state_q == StRd) && bus.m_grant;
  assign wr_issue  = (state_q == StWr) && bus.m_grant;
  assign last_beat = (idx_q == last_q);
  assign burst_len = AW'(last_q) + AW'(1);
  assign rem_next  = rem_q - burst_len;

  // Select the next write word; forward m_din when that slot is captured this cycle
  // (single-word bursts load m_dout on the same edge the only read lands).
  always_comb begin
    wr_sel  = (state_q == StWr) ? idx_q + IW'(1) : '0;
    wr_word = buf_mem[wr_sel];
    if (rd_pend_q && (cap_idx_q == wr_sel)) begin
      wr_word = bus.m_din;
    end
  end

  // Control FSM with registered bus and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      src_q     <= '0;
      dst_q     <= '0;
      rem_q     <= '0;
      idx_q     <= '0;
      last_q    <= '0;
      cap_idx_q <= '0;
      rd_pend_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      req_q     <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      dout_q    <= '0;
    end else begin
      rd_pend_q <= 1'b0;
      done_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (len != '0) begin
              src_q   <= src_addr;
              dst_q   <= dst_addr;
              rem_q   <= len;
              last_q  <= burst_last(len);
              idx_q   <= '0;
              busy_q  <= 1'b1;
              req_q   <= 1'b1;
              wr_q    <= 1'b0;
              addr_q  <= src_addr;
              state_q <= StReq;
            end else begin
              // Empty copy: report completion without touching the bus.
              done_q  <= 1'b1;
              state_q <= StFin;
            end
          end
        end
        StReq: begin
          if (bus.m_grant) begin
            state_q <= StRd;
          end
        end
        StRd: begin
          if (rd_issue) begin
            rd_pend_q <= 1'b1;
            cap_idx_q <= idx_q;
            if (last_beat) begin
              idx_q   <= '0;
              state_q <= StRdDrain;
            end else begin
              idx_q  <= idx_q + IW'(1);
              addr_q <= src_q + AW'(idx_q) + AW'(1);
            end
          end
        end
        StRdDrain: begin
          wr_q    <= 1'b1;
          addr_q  <= dst_q;
          dout_q  <= wr_word;
          state_q <= StWr;
        end
        StWr: begin
          if (wr_issue) begin
            if (last_beat) begin
              idx_q <= '0;
              wr_q  <= 1'b0;
              src_q <= src_q + burst_len;
              dst_q <= dst_q + burst_len;
              rem_q <= rem_next;
              if (rem_next == '0) begin
                req_q   <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= StFin;
              end else begin
                // Keep the bus and go straight into the next read burst.
                last_q  <= burst_last(rem_next);
                addr_q  <= src_q + burst_len;
                state_q <= StRd;
              end
            end else begin
              idx_q  <= idx_q + IW'(1);
              addr_q <= dst_q + AW'(idx_q) + AW'(1);
              dout_q <= wr_word;
            end
          end
        end
        StFin: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Burst buffer: capture read data one cycle after each issued read address.
  always_ff @(posedge clk) begin
    if (rd_pend_q) begin
      buf_mem[cap_idx_q] <= bus.m_din;
    end
  end

`ifdef COPY_CHECKSUM_EN
  logic [DW-1:0] chk_q;

  // Checksum: cleared on an accepted start, folds in every granted write word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chk_q <= '0;
    end else if ((state_q == StIdle) && start) begin
      chk_q <= '0;
    end else if (wr_issue) begin
      chk_q <= chk_q ^ dout_q;
    end
  end

  assign chk_out = chk_q;
`else
  assign chk_out = '0;
`endif

  assign busy       = busy_q;
  assign done       = done_q;
  assign bus.m_req  = req_q;
  assign bus.m_wr   = wr_q;
  assign bus.m_addr = addr_q;
  assign bus.m_dout = dout_q;

endmodule

// File: tb/tb_bus_copy_master.sv
// Directed bench for bus_copy_master: table of copy jobs plus hand-written
// reset and checksum sequences, against a registered arbiter and memory slave.
module tb_bus_copy_master;
  localparam int unsigned AW        = 16;
  localparam int unsigned DW        = 64;
  localparam int unsigned BUF_DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [AW-1:0] len;
  logic          busy;
  logic          done;
  logic [DW-1:0] chk_out;
  logic          grant_en;

  bus_copy_master_if #(.AW(AW), .DW(DW)) bus ();

  bus_copy_master #(
    .BUF_DEPTH(BUF_DEPTH),
    .AW       (AW),
    .DW       (DW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .src_addr(src_addr),
    .dst_addr(dst_addr),
    .len     (len),
    .busy    (busy),
    .done    (done),
    .chk_out (chk_out),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Written words; unwritten addresses read back as the fixed pattern.
  logic [DW-1:0] wmem [int];
  int unsigned   wr_count = 0;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    case (a)
      16'h2000: return 64'h1;
      16'h2001: return 64'h2;
      16'h2002: return 64'h4;
      default:  return {16'hC0DE, a, ~a, a ^ 16'h5A5A};
    endcase
  endfunction

  function automatic logic [DW-1:0] rd_mem(input logic [AW-1:0] a);
    if (wmem.exists(int'(a))) return wmem[int'(a)];
    return pat(a);
  endfunction

  // Arbiter: grant one cycle after request, gated by the bench.
  always @(posedge clk or posedge reset) begin
    if (reset) bus.m_grant <= 1'b0;
    else       bus.m_grant <= bus.m_req && grant_en;
  end

  // Slave: read data one cycle after the address, writes on granted write cycles.
  always @(posedge clk) begin
    bus.m_din <= rd_mem(bus.m_addr);
    if (bus.m_req && bus.m_grant && bus.m_wr) begin
      wmem[int'(bus.m_addr)] = bus.m_dout;
      wr_count = wr_count + 1;
    end
  end

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One copy job: latency to done, pulse width, bus usage and memory result.
  task automatic run_copy(input string tag, input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input logic [AW-1:0] l, input int exp_cyc, input bit drop);
    int          cyc      = 0;
    bit          req_seen = 1'b0;
    bit          req_gap  = 1'b0;
    int unsigned wc0      = wr_count;
    @(negedge clk);
    src_addr = s;
    dst_addr = d;
    len      = l;
    start    = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        start = 1'b0;
        check({tag, " busy_after_start"}, 64'(busy), 64'(l != 0));
      end
      if (drop && c == 4) grant_en = 1'b0;
      if (drop && c == 6) grant_en = 1'b1;
      if (bus.m_req) req_seen = 1'b1;
      if (busy && !bus.m_req) req_gap = 1'b1;
      if (done) begin
        cyc = c;
        break;
      end
    end
    check({tag, " cycles_to_done"}, 64'(cyc), 64'(exp_cyc));
    @(posedge clk);
    #1;
    check({tag, " done_one_pulse"}, 64'(done), 64'(0));
    check({tag, " busy_low_after"}, 64'(busy), 64'(0));
    check({tag, " req_low_after"}, 64'(bus.m_req), 64'(0));
    check({tag, " req_seen"}, 64'(req_seen), 64'(l != 0));
    check({tag, " req_continuous"}, 64'(req_gap), 64'(0));
    check({tag, " write_count"}, 64'(wr_count - wc0), 64'(l));
    for (int i = 0; i < int'(l); i++) begin
      check($sformatf("%s data[%0d]", tag, i), rd_mem(d + AW'(i)), pat(s + AW'(i)));
    end
    check({tag, " guard_below"}, rd_mem(d - AW'(1)), pat(d - AW'(1)));
    check({tag, " guard_above"}, rd_mem(d + l), pat(d + l));
    repeat (2) @(posedge clk);
  endtask

  typedef struct {
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [AW-1:0] len;
    int            cyc;
    bit            drop;
  } vec_t;

  vec_t          vecs [6];
  logic [DW-1:0] exp_chk;

  initial begin
    vecs[0] = '{src: 16'h0010, dst: 16'h0100, len: 16'd3,  cyc: 10, drop: 1'b0};
    vecs[1] = '{src: 16'h0200, dst: 16'h0300, len: 16'd10, cyc: 26, drop: 1'b0};
    vecs[2] = '{src: 16'h0400, dst: 16'h0500, len: 16'd0,  cyc: 1,  drop: 1'b0};
    vecs[3] = '{src: 16'h0600, dst: 16'h0700, len: 16'd1,  cyc: 6,  drop: 1'b0};
    vecs[4] = '{src: 16'h0800, dst: 16'h0900, len: 16'd5,  cyc: 15, drop: 1'b0};
    vecs[5] = '{src: 16'hFFFE, dst: 16'h1000, len: 16'd4,  cyc: 14, drop: 1'b1};

    reset    = 1'b1;
    start    = 1'b0;
    grant_en = 1'b1;
    src_addr = '0;
    dst_addr = '0;
    len      = '0;
    repeat (3) @(negedge clk);
    check("reset busy",   64'(busy),      64'(0));
    check("reset done",   64'(done),      64'(0));
    check("reset chk",    chk_out,        64'(0));
    check("reset m_req",  64'(bus.m_req), 64'(0));
    check("reset m_wr",   64'(bus.m_wr),  64'(0));
    check("reset m_addr", 64'(bus.m_addr), 64'(0));
    check("reset m_dout", bus.m_dout,     64'(0));
    reset = 1'b0;
    begin
      bit idle_req = 1'b0;
      repeat (6) begin
        @(posedge clk);
        #1;
        if (bus.m_req || busy || done) idle_req = 1'b1;
      end
      check("idle no activity", 64'(idle_req), 64'(0));
    end

    for (int v = 0; v < 6; v++) begin
      run_copy($sformatf("vec%0d", v), vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].cyc,
               vecs[v].drop);
    end

    // Checksum over words 1, 2, 4.
    run_copy("chk", 16'h2000, 16'h2100, 16'd3, 10, 1'b0);
`ifdef COPY_CHECKSUM_EN
    exp_chk = 64'h7;
`else
    exp_chk = 64'h0;
`endif
    check("chk_out after copy", chk_out, exp_chk);
    repeat (3) @(posedge clk);
    #1;
    check("chk_out holds", chk_out, exp_chk);

    // Reset asserted while writes are in flight.
    begin
      bit in_wr = 1'b0;
      @(negedge clk);
      src_addr = 16'h3000;
      dst_addr = 16'h3100;
      len      = 16'd4;
      start    = 1'b1;
      for (int c = 0; c < 50; c++) begin
        @(posedge clk);
        #1;
        start = 1'b0;
        if (bus.m_wr && bus.m_grant) begin
          in_wr = 1'b1;
          break;
        end
      end
      check("reached write phase", 64'(in_wr), 64'(1));
      reset = 1'b1;
      #1;
      check("midreset m_req", 64'(bus.m_req),  64'(0));
      check("midreset busy",  64'(busy),       64'(0));
      check("midreset m_wr",  64'(bus.m_wr),   64'(0));
      check("midreset m_addr", 64'(bus.m_addr), 64'(0));
      check("midreset chk",   chk_out,         64'(0));
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
    end
    run_copy("post_reset", 16'h3200, 16'h3300, 16'd2, 8, 1'b0);
`ifdef COPY_CHECKSUM_EN
    exp_chk = pat(16'h3200) ^ pat(16'h3201);
`else
    exp_chk = 64'h0;
`endif
    check("post_reset chk", chk_out, exp_chk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
